seg_fetch_pipelined: RTL and testbench

SEG_FETCH_PIPELINED -- requirements
Module: seg_fetch_pipelined

---
 rtl/seg_fetch_pipelined.sv | 100 ++++++++++
 tb/tb_seg_fetch_pipelined.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_fetch_pipelined.sv
// Instruction fetch stage: program-loadable instruction RAM, PC sequencing with
// branch redirect, stall/flush handling and a registered IF/ID output.
module seg_fetch_pipelined #(
    parameter int              LEN       = 32,
    parameter int              RAM_DEPTH = 2048,
    parameter int              PC_STEP   = 1,
    parameter logic [LEN-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_run,
    input  logic           i_stall,
    input  logic           i_flush,
    input  logic           i_PCSrc,
    input  logic [LEN-1:0] i_PC_branch,
    input  logic           i_load_en,
    input  logic [LEN-1:0] i_load_addr,
    input  logic [LEN-1:0] i_load_data,
    output logic [LEN-1:0] o_instruction,
    output logic [LEN-1:0] o_PC,
    output logic           o_valid,
    output logic           o_halt
);

    localparam int             AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [LEN-1:0] STEP = LEN'(PC_STEP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic [LEN-1:0] instr;
        logic [LEN-1:0] pc;
        logic           valid;
    } ifid_t;

    state_t         state;
    ifid_t          ifid;
    logic           halt_q;
    logic [LEN-1:0] pc;
    logic [LEN-1:0] mem [RAM_DEPTH];
    logic [LEN-1:0] fetch_word;
    logic [LEN-1:0] pc_seq;
    logic [LEN-1:0] pc_next;
    logic           unused_addr_hi;

    assign fetch_word     = mem[pc[AW-1:0]];
    assign pc_seq         = pc + STEP;
    assign pc_next        = i_PCSrc ? i_PC_branch : pc_seq;
    assign unused_addr_hi = ^i_load_addr;

    // Memory has no reset so a program survives a restart; writable only in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst && state == S_IDLE && i_load_en)
            mem[i_load_addr[AW-1:0]] <= i_load_data;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ifid   <= '0;
            halt_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pc <= '0;
                    if (i_run) state <= S_RUN;
                end
                S_RUN: begin
                    if (i_flush) begin
                        ifid <= '0;
                        pc   <= pc_next;
                    end else if (!i_stall) begin
                        ifid.instr <= fetch_word;
                        ifid.pc    <= pc_seq;
                        ifid.valid <= 1'b1;
                        // The halt word is delivered once, then the PC freezes on it.
                        if (fetch_word == HALT_WORD) begin
                            halt_q <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc <= pc_next;
                        end
                    end
                end
                S_HALT: begin
                    ifid.instr <= '0;
                    ifid.valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_instruction = ifid.instr;
    assign o_PC          = ifid.pc;
    assign o_valid       = ifid.valid;
    assign o_halt        = halt_q;

endmodule

// File: tb/tb_seg_fetch_pipelined.sv
// Randomized scoreboard bench for seg_fetch_pipelined against an abstract fetch model.
module tb_seg_fetch_pipelined;

    localparam int          DEPTH = 64;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0, stall = 1'b0, flush = 1'b0, pcsrc = 1'b0, load_en = 1'b0;
    logic [31:0] br = '0, load_addr = '0, load_data = '0;
    logic [31:0] o_instruction, o_PC;
    logic        o_valid, o_halt;

    seg_fetch_pipelined #(.LEN(32), .RAM_DEPTH(DEPTH), .PC_STEP(1), .HALT_WORD(HALT)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_stall(stall), .i_flush(flush),
        .i_PCSrc(pcsrc), .i_PC_branch(br), .i_load_en(load_en), .i_load_addr(load_addr),
        .i_load_data(load_data), .o_instruction(o_instruction), .o_PC(o_PC),
        .o_valid(o_valid), .o_halt(o_halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;

    // Reference model: a program array, a PC, and "running"/"halted" flags.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    bit          m_running, m_halted;
    logic [31:0] e_instr, e_pc;
    logic        e_valid, e_halt;
    int          halted_for;

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom();
        return (w == HALT) ? 32'h0 : w;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_running = 0; m_halted = 0;
        e_instr = 0; e_pc = 0; e_valid = 0; e_halt = 0;
        halted_for = 0;
    endtask

    task automatic model_edge();
        logic [31:0] target, w;
        target = pcsrc ? br : m_pc + 32'd1;
        if (!m_running && !m_halted) begin
            if (load_en) m_mem[load_addr % DEPTH] = load_data;
            if (run) m_running = 1;
        end else if (m_running) begin
            if (flush) begin
                e_instr = 0; e_pc = 0; e_valid = 0;
                m_pc = target;
            end else if (!stall) begin
                w = m_mem[m_pc % DEPTH];
                e_instr = w; e_pc = m_pc + 32'd1; e_valid = 1;
                if (w == HALT) begin
                    m_halted = 1; m_running = 0; e_halt = 1;
                end else begin
                    m_pc = target;
                end
            end
        end else begin
            e_instr = 0; e_valid = 0;
            halted_for++;
        end
    endtask

    // One clock: predict the edge, queue the expectation, advance to edge+2.
    task automatic cycle();
        exp_t e;
        model_edge();
        e.cyc = cyc + 1; e.instr = e_instr; e.pc = e_pc; e.valid = e_valid; e.halt = e_halt;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        run = 0; stall = 0; flush = 0; pcsrc = 0; load_en = 0;
        br = 0; load_addr = 0; load_data = 0;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (o_instruction !== 0 || o_PC !== 0 || o_valid !== 0 || o_halt !== 0) begin
            n_err++;
            $display("FAIL %s: got instr=%h pc=%h valid=%b halt=%b, want all zero",
                     name, o_instruction, o_PC, o_valid, o_halt);
        end
    endtask

    // Asserted mid-cycle (edge+3); outputs must clear before the next edge.
    task automatic do_reset();
        #1 rst = 0;
        #1 check_zero("async_reset");
        q.delete();
        model_reset();
        clear_in();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;
    endtask

    // Monitor: samples one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc != cyc || o_instruction !== e.instr || o_PC !== e.pc ||
                    o_valid !== e.valid || o_halt !== e.halt) begin
                    n_err++;
                    $display("FAIL fetch cyc=%0d: got instr=%h pc=%h valid=%b halt=%b, want instr=%h pc=%h valid=%b halt=%b (slot %0d)",
                             cyc, o_instruction, o_PC, o_valid, o_halt,
                             e.instr, e.pc, e.valid, e.halt, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_in();
        #1 rst = 0;
        #2 check_zero("power_on_reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;

        // Program: A,B,C,HALT then random non-halt words.
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = i;
            case (i)
                0: load_data = 32'hA0A0_0001;
                1: load_data = 32'hB0B0_0002;
                2: load_data = 32'hC0C0_0003;
                3: load_data = HALT;
                default: load_data = rnd_word();
            endcase
            cycle();
        end
        clear_in();
        run = 1; cycle(); run = 0;
        repeat (8) cycle();
        stall = 1; run = 1; load_en = 1; cycle(); cycle(); clear_in();

        // Replace the halt word, starting the run in the same cycle as the load.
        do_reset();
        load_en = 1; load_addr = 3; load_data = rnd_word(); run = 1; cycle(); clear_in();
        cycle();
        pcsrc = 1; br = 10; cycle(); pcsrc = 0;
        cycle();
        pcsrc = 1; br = 2; cycle(); pcsrc = 0;
        stall = 1; pcsrc = 1; br = 40; cycle(); cycle(); clear_in();
        cycle(); cycle();
        flush = 1; stall = 1; pcsrc = 1; br = 5; cycle(); clear_in();
        cycle(); cycle();
        load_en = 1; load_addr = 0; load_data = 32'h1234_5678; cycle(); clear_in();
        pcsrc = 1; br = DEPTH - 1; cycle(); pcsrc = 0;
        cycle(); cycle();
        pcsrc = 1; br = 32'hFFFF_FFFF; cycle(); pcsrc = 0;
        cycle(); cycle();
        flush = 1; pcsrc = 1; br = 32'hFFFF_FFFF; cycle(); clear_in();
        cycle(); cycle();

        // Rerun confirms the load during RUN was dropped.
        do_reset();
        run = 1; cycle(); run = 0;
        cycle(); cycle();

        // Flush suppresses a halt fetch.
        do_reset();
        load_en = 1; load_addr = 7; load_data = HALT; cycle();
        load_addr = 8; load_data = rnd_word(); run = 1; cycle(); clear_in();
        pcsrc = 1; br = 7; cycle(); clear_in();
        flush = 1; cycle(); flush = 0;
        cycle(); cycle(); cycle();

        // Randomized phase.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            load_en = 1; load_addr = $urandom_range(4, DEPTH - 1); load_data = HALT; cycle();
        end
        clear_in();
        run = 1; cycle(); run = 0;
        for (int n = 0; n < 600; n++) begin
            if (m_halted && halted_for > 2) begin
                do_reset();
                repeat ($urandom_range(1, 4)) begin
                    load_en = 1; load_addr = $urandom();
                    load_data = ($urandom_range(0, 3) == 0) ? HALT : rnd_word();
                    cycle();
                end
                clear_in();
                run = 1; cycle(); run = 0;
            end else if ($urandom_range(0, 99) == 0) begin
                do_reset();
                run = 1; cycle(); run = 0;
            end else begin
                stall     = ($urandom_range(0, 9) < 3);
                flush     = ($urandom_range(0, 9) == 0);
                pcsrc     = ($urandom_range(0, 6) == 0);
                br        = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 2 * DEPTH);
                load_en   = $urandom_range(0, 1);
                load_addr = $urandom();
                load_data = rnd_word();
                run       = $urandom_range(0, 1);
                cycle();
            end
        end
        clear_in();
        cycle();

        @(posedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
